// File: rtl/moving_average_ctrl_pkg.sv
// Shared definitions for the moving-average sequencer: FSM state codes, engine mode codes
// and the number of warm-up results each mode produces before its window is full.
package moving_average_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int WARM_W = 5;

  localparam logic [1:0] ST_RST_ENG = 2'd0;
  localparam logic [1:0] ST_WARMUP  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [2:0] MODE_BYPASS = 3'b000;
  localparam logic [2:0] MODE_2PT    = 3'b001;
  localparam logic [2:0] MODE_3PT    = 3'b010;
  localparam logic [2:0] MODE_4PT    = 3'b011;
  localparam logic [2:0] MODE_8PT    = 3'b100;
  localparam logic [2:0] MODE_16PT   = 3'b101;

  // Undefined codes behave as bypass in the engine, so they need no warm-up.
  function automatic logic [WARM_W-1:0] warm_count(input logic [2:0] mode);
    case (mode)
      MODE_2PT:  return WARM_W'(2);
      MODE_3PT:  return WARM_W'(3);
      MODE_4PT:  return WARM_W'(4);
      MODE_8PT:  return WARM_W'(8);
      MODE_16PT: return WARM_W'(16);
      default:   return WARM_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/mavg_result_fifo.sv
// Small synchronous first-word-fall-through FIFO holding averaged results.
// The head reads as zero while empty so the output bus is clean after reset.
module mavg_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequencer in front of a moving-average engine: resets it on reconfiguration, strobes samples
// in, drops warm-up results and queues the rest behind a credit-limited output FIFO.
module moving_average_ctrl
  import moving_average_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2,
  parameter int MIN_GAP    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_mode,
  input  logic        cfg_refresh_mode,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        eng_rst_n,
  output logic        eng_enable,
  output logic        eng_data_refresh,
  output logic [15:0] eng_din,
  output logic [2:0]  eng_mode,
  output logic        eng_output_refresh_mode,
  input  logic [15:0] eng_dout,
  input  logic        eng_output_pulse,
  output logic [7:0]  discard_cnt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OW  = CW + 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int GW  = 8;

  logic [1:0]        state_reg;
  logic [RCW-1:0]    rst_cnt_reg;
  logic [WARM_W-1:0] warm_cnt_reg;
  logic [GW-1:0]     gap_cnt_reg;
  logic              refresh_reg;
  logic              refresh_tag_reg;
  logic              inflight_reg;
  logic              inflight_tag_reg;
  logic [15:0]       eng_din_reg;
  logic [2:0]        eng_mode_reg;
  logic              eng_orm_reg;
  logic [7:0]        discard_cnt_reg;

  logic              active;
  logic              cfg_accept;
  logic              s_accept;
  logic              pulse_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     occupancy;
  logic [WARM_W-1:0] warm_target;
  logic [WARM_W-1:0] warm_cnt_next;

  assign active        = (state_reg == ST_WARMUP) || (state_reg == ST_RUN);
  assign warm_target   = warm_count(eng_mode_reg);
  assign warm_cnt_next = warm_cnt_reg + 1'b1;

  // A strobe still on its way to the engine or a result not yet returned each hold one
  // FIFO credit, so the FIFO can never be asked to take more than it has room for.
  assign occupancy  = {1'b0, fifo_count} + OW'(refresh_reg) + OW'(inflight_reg);
  assign cfg_ready  = active & ~refresh_reg & ~inflight_reg;
  assign s_ready    = active & (gap_cnt_reg == '0) & ~cfg_valid & (occupancy < OW'(FIFO_DEPTH));
  assign cfg_accept = cfg_valid & cfg_ready;
  assign s_accept   = s_valid & s_ready;

  assign pulse_ok  = eng_output_pulse & inflight_reg & (state_reg != ST_RST_ENG);
  assign fifo_push = pulse_ok & ~inflight_tag_reg;
  assign fifo_pop  = m_valid & m_ready;

  assign eng_rst_n               = (state_reg != ST_RST_ENG);
  assign eng_enable              = (state_reg != ST_RST_ENG);
  assign eng_data_refresh        = refresh_reg;
  assign eng_din                 = eng_din_reg;
  assign eng_mode                = eng_mode_reg;
  assign eng_output_refresh_mode = eng_orm_reg;
  assign discard_cnt             = discard_cnt_reg;
  assign m_valid                 = ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_RST_ENG;
      rst_cnt_reg      <= '0;
      warm_cnt_reg     <= '0;
      gap_cnt_reg      <= '0;
      refresh_reg      <= 1'b0;
      refresh_tag_reg  <= 1'b0;
      inflight_reg     <= 1'b0;
      inflight_tag_reg <= 1'b0;
      eng_din_reg      <= '0;
      eng_mode_reg     <= MODE_BYPASS;
      eng_orm_reg      <= 1'b1;
      discard_cnt_reg  <= '0;
    end else begin
      refresh_reg      <= s_accept;
      refresh_tag_reg  <= s_accept & (state_reg == ST_WARMUP);
      inflight_reg     <= refresh_reg;
      inflight_tag_reg <= refresh_tag_reg;

      if (s_accept) begin
        eng_din_reg <= s_data;
        gap_cnt_reg <= GW'(MIN_GAP);
      end else if (gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end

      if (pulse_ok && inflight_tag_reg && discard_cnt_reg != 8'hFF) begin
        discard_cnt_reg <= discard_cnt_reg + 1'b1;
      end

      if (cfg_accept) begin
        state_reg       <= ST_RST_ENG;
        rst_cnt_reg     <= '0;
        warm_cnt_reg    <= '0;
        eng_mode_reg    <= cfg_mode;
        eng_orm_reg     <= cfg_refresh_mode;
        discard_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_RST_ENG: begin
            if (rst_cnt_reg == RCW'(RST_CYCLES - 1)) begin
              rst_cnt_reg <= '0;
              state_reg   <= (warm_target == '0) ? ST_RUN : ST_WARMUP;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end
          end
          ST_WARMUP: begin
            if (s_accept) begin
              warm_cnt_reg <= warm_cnt_next;
              if (warm_cnt_next == warm_target) state_reg <= ST_RUN;
            end
          end
          ST_RUN: begin
          end
          default: state_reg <= ST_RST_ENG;
        endcase
      end
    end
  end

  mavg_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (eng_dout),
    .pop       (fifo_pop),
    .head      (m_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Drives moving_average_ctrl against a behavioural averaging engine and checks results,
// discard counts, reset timing and strobe spacing against a sample-list reference model.
module tb_moving_average_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int RST_CYCLES = 2;
  localparam int MIN_GAP    = 2;

  typedef logic [15:0] vq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_mode = 3'b000;
  logic        cfg_refresh_mode = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        eng_rst_n;
  logic        eng_enable;
  logic        eng_data_refresh;
  logic [15:0] eng_din;
  logic [2:0]  eng_mode;
  logic        eng_output_refresh_mode;
  logic [15:0] eng_dout = '0;
  logic        eng_output_pulse = 1'b0;
  logic [7:0]  discard_cnt;

  int warm_tab [8] = '{0, 2, 3, 4, 8, 16, 0, 0};
  int taps_tab [8] = '{1, 2, 3, 4, 8, 16, 1, 1};

  // reference model state
  int          md;
  logic        orm_m;
  int          acc_q[$];
  logic [15:0] exp_q[$];
  int          exp_disc;
  int          rx_count;
  int          cyc;
  int          last_ref;
  bit          exact_gap;
  int          ready_mode;
  bit          seen_s_acc, seen_cfg_acc, seen_s_ready, seen_cfg_ready, seen_rst_low;
  int          n_checks;
  int          n_fail;
  int          eng_hist [16];

  always #5 clk = ~clk;

  moving_average_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RST_CYCLES (RST_CYCLES),
    .MIN_GAP    (MIN_GAP)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_valid               (cfg_valid),
    .cfg_ready               (cfg_ready),
    .cfg_mode                (cfg_mode),
    .cfg_refresh_mode        (cfg_refresh_mode),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .s_data                  (s_data),
    .m_valid                 (m_valid),
    .m_ready                 (m_ready),
    .m_data                  (m_data),
    .eng_rst_n               (eng_rst_n),
    .eng_enable              (eng_enable),
    .eng_data_refresh        (eng_data_refresh),
    .eng_din                 (eng_din),
    .eng_mode                (eng_mode),
    .eng_output_refresh_mode (eng_output_refresh_mode),
    .eng_dout                (eng_dout),
    .eng_output_pulse        (eng_output_pulse),
    .discard_cnt             (discard_cnt)
  );

  // Behavioural engine: N-tap window over the most recent samples, result one cycle after the strobe.
  function automatic logic [15:0] eng_avg(input logic [15:0] din, input logic [2:0] mode);
    int n = taps_tab[mode];
    int s = int'($signed(din));
    for (int i = 0; i < n - 1; i++) s += eng_hist[i];
    return 16'(s / n);
  endfunction

  always @(posedge clk) begin
    if (!eng_rst_n) begin
      for (int i = 0; i < 16; i++) eng_hist[i] <= 0;
      eng_output_pulse <= 1'b0;
      eng_dout <= '0;
    end else begin
      eng_output_pulse <= 1'b0;
      if (eng_enable && eng_data_refresh) begin
        for (int i = 15; i > 0; i--) eng_hist[i] <= eng_hist[i-1];
        eng_hist[0] <= int'($signed(eng_din));
        if (eng_output_refresh_mode) begin
          eng_output_pulse <= 1'b1;
          eng_dout <= eng_avg(eng_din, eng_mode);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ref_avg();
    int n = taps_tab[md];
    int s = 0;
    for (int i = 0; i < n && i < acc_q.size(); i++) s += acc_q[acc_q.size() - 1 - i];
    return 16'(s / n);
  endfunction

  task automatic monitor();
    seen_s_acc     = s_valid & s_ready;
    seen_cfg_acc   = cfg_valid & cfg_ready;
    seen_s_ready   = s_ready;
    seen_cfg_ready = cfg_ready;
    seen_rst_low   = ~eng_rst_n;
    if (seen_cfg_acc) begin
      md = int'(cfg_mode);
      orm_m = cfg_refresh_mode;
      acc_q.delete();
      exp_disc = 0;
      $display("cfg mode=%0d refresh=%0d", cfg_mode, cfg_refresh_mode);
    end
    if (seen_s_acc) begin
      acc_q.push_back(int'($signed(s_data)));
      if (orm_m) begin
        if (acc_q.size() <= warm_tab[md]) begin
          if (exp_disc < 255) exp_disc++;
        end else begin
          exp_q.push_back(ref_avg());
        end
      end
    end
    if (m_valid && m_ready) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        check_eq("m_extra", 32'(exp_q.size()), 1);
      end else begin
        $display("rx data=%0d", $signed(m_data));
        check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
    if (eng_data_refresh) begin
      if (last_ref >= 0) begin
        if (exact_gap) check_eq("gap_exact", 32'(cyc - last_ref), 32'(MIN_GAP + 1));
        else           check_eq("gap_min", 32'(cyc - last_ref >= MIN_GAP + 1), 1);
      end
      last_ref = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst) begin
      md = 0; orm_m = 1'b1; acc_q.delete(); exp_q.delete(); exp_disc = 0;
      seen_s_acc = 0; seen_cfg_acc = 0; seen_s_ready = 0; seen_cfg_ready = 0; seen_rst_low = 1;
    end else begin
      monitor();
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    m_ready = (mode == 1);
  endtask

  task automatic count_rst_low(input string tag);
    int low = 0;
    for (int i = 0; i < RST_CYCLES + 4; i++) begin
      step();
      if (seen_rst_low) low++;
    end
    check_eq(tag, 32'(low), 32'(RST_CYCLES));
  endtask

  task automatic configure(input logic [2:0] mode, input logic orm);
    int n = 0;
    cfg_mode = mode;
    cfg_refresh_mode = orm;
    cfg_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!seen_cfg_acc && n < 60);
    check_eq("cfg_taken", 32'(seen_cfg_acc), 1);
    cfg_valid = 1'b0;
    count_rst_low("cfg_rst_cycles");
  endtask

  task automatic stream(input vq_t vals, input int budget, output int acc);
    int cycles = 0;
    acc = 0;
    while (acc < vals.size() && cycles < budget) begin
      s_valid = 1'b1;
      s_data = vals[acc];
      step();
      cycles++;
      if (seen_s_acc) acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    set_ready(1);
    repeat (4) step();
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 0);
    check_eq("drain_mvalid", 32'(m_valid), 0);
  endtask

  function automatic vq_t rand_vals(input int n);
    vq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 65535)));
    return q;
  endfunction

  initial begin
    vq_t v;
    vq_t rest;
    int acc;
    int base;
    md = 0; orm_m = 1'b1; exp_disc = 0; rx_count = 0; cyc = 0; last_ref = -1;
    exact_gap = 0; ready_mode = 0; n_checks = 0; n_fail = 0;

    // 1: reset state, bypass pass-through
    repeat (3) step();
    check_eq("rst_eng_rst_n", 32'(eng_rst_n), 0);
    check_eq("rst_eng_enable", 32'(eng_enable), 0);
    check_eq("rst_refresh", 32'(eng_data_refresh), 0);
    check_eq("rst_eng_din", 32'(eng_din), 0);
    check_eq("rst_eng_mode", 32'(eng_mode), 0);
    check_eq("rst_eng_orm", 32'(eng_output_refresh_mode), 1);
    check_eq("rst_m_valid", 32'(m_valid), 0);
    check_eq("rst_m_data", 32'(m_data), 0);
    check_eq("rst_discard", 32'(discard_cnt), 0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 0);
    check_eq("rst_s_ready", 32'(s_ready), 0);
    rst = 1'b0;
    count_rst_low("rel_rst_cycles");
    configure(3'b000, 1'b1);
    set_ready(1);
    base = rx_count;
    v = '{16'd100, 16'd200, 16'hFED4};
    stream(v, 40, acc);
    check_eq("t1_accepts", 32'(acc), 3);
    drain();
    check_eq("t1_results", 32'(rx_count - base), 3);
    check_eq("t1_discard", 32'(discard_cnt), 0);

    // 2: 2-point, two warm-up results dropped
    configure(3'b001, 1'b1);
    set_ready(2);
    base = rx_count;
    v = '{16'd10, 16'd20, 16'd30, 16'd40};
    stream(v, 60, acc);
    drain();
    check_eq("t2_discard", 32'(discard_cnt), 2);
    check_eq("t2_results", 32'(rx_count - base), 2);

    // 3: 16-point, 20 random samples
    configure(3'b101, 1'b1);
    set_ready(2);
    base = rx_count;
    stream(rand_vals(20), 300, acc);
    check_eq("t3_accepts", 32'(acc), 20);
    drain();
    check_eq("t3_discard", 32'(discard_cnt), 16);
    check_eq("t3_results", 32'(rx_count - base), 4);

    // 4: backpressure fills the FIFO, then drains in order
    configure(3'b000, 1'b1);
    set_ready(0);
    base = rx_count;
    v = rand_vals(10);
    stream(v, 30, acc);
    check_eq("t4_accepts_full", 32'(acc), FIFO_DEPTH);
    step();
    check_eq("t4_s_ready_low", 32'(seen_s_ready), 0);
    check_eq("t4_m_valid", 32'(m_valid), 1);
    rest = {};
    for (int i = acc; i < 10; i++) rest.push_back(v[i]);
    set_ready(1);
    stream(rest, 60, acc);
    check_eq("t4_accepts_rest", 32'(acc), 10 - FIFO_DEPTH);
    drain();
    check_eq("t4_results", 32'(rx_count - base), 10);

    // 5: cfg and sample in the same cycle, cfg wins
    cfg_mode = 3'b010;
    cfg_refresh_mode = 1'b1;
    cfg_valid = 1'b1;
    s_valid = 1'b1;
    s_data = 16'd777;
    step();
    check_eq("t5_s_blocked", 32'(seen_s_ready), 0);
    check_eq("t5_cfg_taken", 32'(seen_cfg_acc), 1);
    cfg_valid = 1'b0;
    s_valid = 1'b0;
    count_rst_low("t5_rst_cycles");
    set_ready(2);
    base = rx_count;
    stream(rand_vals(12), 200, acc);
    drain();
    check_eq("t5_discard", 32'(discard_cnt), 3);
    check_eq("t5_results", 32'(rx_count - base), 9);
    configure(3'b011, 1'b0);
    set_ready(0);
    base = rx_count;
    stream(rand_vals(6), 60, acc);
    check_eq("t5_noresult_accepts", 32'(acc), 6);
    drain();
    check_eq("t5_noresult_results", 32'(rx_count - base), 0);
    check_eq("t5_noresult_discard", 32'(discard_cnt), 0);

    // 6: strobe spacing with continuous valid, then reset mid-stream
    configure(3'b000, 1'b1);
    set_ready(1);
    base = rx_count;
    last_ref = -1;
    exact_gap = 1;
    stream(rand_vals(6), 60, acc);
    exact_gap = 0;
    drain();
    check_eq("t6_results", 32'(rx_count - base), 6);
    s_valid = 1'b1;
    s_data = 16'd1234;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_eng_rst_n", 32'(eng_rst_n), 0);
    check_eq("t6_rst_enable", 32'(eng_enable), 0);
    check_eq("t6_rst_refresh", 32'(eng_data_refresh), 0);
    check_eq("t6_rst_eng_din", 32'(eng_din), 0);
    check_eq("t6_rst_m_valid", 32'(m_valid), 0);
    check_eq("t6_rst_m_data", 32'(m_data), 0);
    check_eq("t6_rst_s_ready", 32'(s_ready), 0);
    check_eq("t6_rst_cfg_ready", 32'(cfg_ready), 0);
    s_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    count_rst_low("t6_rel_rst_cycles");
    configure(3'b100, 1'b1);
    set_ready(2);
    base = rx_count;
    stream(rand_vals(10), 150, acc);
    drain();
    check_eq("t6_discard", 32'(discard_cnt), 8);
    check_eq("t6_results_after", 32'(rx_count - base), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
